// File: rtl/cond_writeback_stage_if.sv
// Bundle for the conditional writeback stage. It carries the upstream ALU op
// handshake and the register-file writeback slot handshake.
// The stage connects to the slave modport. The producer/consumer side connects
// to the master modport.
interface cond_writeback_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // upstream op
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            cond;
    logic                  set_flags;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [3:0]            alu_flags;
    logic                  alu_writeback;
    logic [3:0]            dest_reg;
    logic                  flush;
    // writeback slot
    logic                  wb_valid;
    logic                  wb_ready;
    logic                  wb_en;
    logic [3:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    modport slave (
        input  in_valid, cond, set_flags, alu_result, alu_flags, alu_writeback,
               dest_reg, flush, wb_ready,
        output in_ready, wb_valid, wb_en, wb_addr, wb_data
    );

    modport master (
        output in_valid, cond, set_flags, alu_result, alu_flags, alu_writeback,
               dest_reg, flush, wb_ready,
        input  in_ready, wb_valid, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/cond_writeback_stage.sv
// Conditional-execution writeback stage.
// Each accepted ALU op is checked against the registered CPSR using the ARM
// condition field. A passing op may update the flags and may write the
// register file. A failing op still occupies the single writeback slot, but
// with wb_en low. The stage also keeps saturating counts of executed and
// skipped ops.
module cond_writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cond_writeback_stage_if.slave bus,
    output logic [3:0]           cpsr,
    output logic [CNT_WIDTH-1:0] exec_count,
    output logic [CNT_WIDTH-1:0] skip_count
);
    logic                  slot_valid;
    logic                  slot_en;
    logic [3:0]            slot_addr;
    logic [DATA_WIDTH-1:0] slot_data;
    logic                  accept;
    logic                  pass;
    logic                  flag_z, flag_c, flag_n, flag_v;

    assign flag_z = cpsr[0];
    assign flag_c = cpsr[1];
    assign flag_n = cpsr[2];
    assign flag_v = cpsr[3];

    // The slot frees up when it is empty or when it is being consumed this cycle.
    assign bus.in_ready = !slot_valid | bus.wb_ready;
    assign accept       = bus.in_valid & bus.in_ready & !bus.flush;

    assign bus.wb_valid = slot_valid;
    assign bus.wb_en    = slot_en;
    assign bus.wb_addr  = slot_addr;
    assign bus.wb_data  = slot_data;

    // Condition evaluation against the registered flags, so an op sees the
    // flags produced by the op accepted on the previous edge.
    always_comb begin
        pass = 1'b0;
        case (bus.cond)
            4'h0: pass = flag_z;
            4'h1: pass = !flag_z;
            4'h2: pass = flag_c;
            4'h3: pass = !flag_c;
            4'h4: pass = flag_n;
            4'h5: pass = !flag_n;
            4'h6: pass = flag_v;
            4'h7: pass = !flag_v;
            4'h8: pass = flag_c & !flag_z;
            4'h9: pass = !flag_c | flag_z;
            4'hA: pass = (flag_n == flag_v);
            4'hB: pass = (flag_n != flag_v);
            4'hC: pass = !flag_z & (flag_n == flag_v);
            4'hD: pass = flag_z | (flag_n != flag_v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Writeback slot. Flush wins over accept. A consume with no accept empties
    // the slot. A consume together with an accept reloads the slot with no bubble.
    // Address and data are left untouched when the slot empties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid <= 1'b0;
            slot_en    <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
        end else if (bus.flush) begin
            slot_valid <= 1'b0;
            slot_en    <= 1'b0;
        end else if (accept) begin
            slot_valid <= 1'b1;
            slot_en    <= pass & bus.alu_writeback;
            slot_addr  <= bus.dest_reg;
            slot_data  <= bus.alu_result;
        end else if (bus.wb_ready) begin
            slot_valid <= 1'b0;
            slot_en    <= 1'b0;
        end
    end

    // Flags load only from an executed op that has its S bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cpsr <= '0;
        else if (accept && pass && bus.set_flags)
            cpsr <= bus.alu_flags;
    end

    // Executed/skipped counters. They stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_count <= '0;
            skip_count <= '0;
        end else if (accept) begin
            if (pass && exec_count != '1)
                exec_count <= exec_count + CNT_WIDTH'(1);
            if (!pass && skip_count != '1)
                skip_count <= skip_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_cond_writeback_stage.sv
// Randomized and directed bench for cond_writeback_stage.
// Two instances receive the same stimulus: one with 16-bit counters and one
// with 4-bit counters, so the saturation behaviour is exercised.
// An abstract reference model predicts every output.
module tb_cond_writeback_stage;
    logic clk;
    logic reset;

    cond_writeback_stage_if #(.DATA_WIDTH(32)) b16 ();
    cond_writeback_stage_if #(.DATA_WIDTH(32)) b4 ();

    logic [3:0]  cpsr16, cpsr4;
    logic [15:0] exec16, skip16;
    logic [3:0]  exec4, skip4;

    cond_writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(b16.slave),
        .cpsr(cpsr16), .exec_count(exec16), .skip_count(skip16)
    );

    cond_writeback_stage #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(b4.slave),
        .cpsr(cpsr4), .exec_count(exec4), .skip_count(skip4)
    );

    assign b4.in_valid      = b16.in_valid;
    assign b4.cond          = b16.cond;
    assign b4.set_flags     = b16.set_flags;
    assign b4.alu_result    = b16.alu_result;
    assign b4.alu_flags     = b16.alu_flags;
    assign b4.alu_writeback = b16.alu_writeback;
    assign b4.dest_reg      = b16.dest_reg;
    assign b4.flush         = b16.flush;
    assign b4.wb_ready      = b16.wb_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit        m_valid, m_en;
    bit [3:0]  m_addr, m_cpsr;
    bit [31:0] m_data;
    int        m_exec, m_skip, m_exec4, m_skip4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Condition codes come in complementary pairs: cond[3:1] picks the base
    // predicate and cond[0] inverts it. AL/NV is the pair whose base is 'true'.
    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
        bit z, cf, n, v, base;
        z = f[0]; cf = f[1]; n = f[2]; v = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic model_clear();
        m_valid = 0; m_en = 0; m_addr = 0; m_data = 0; m_cpsr = 0;
        m_exec = 0; m_skip = 0; m_exec4 = 0; m_skip4 = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wb_valid"}, b16.wb_valid, m_valid);
        chk({tag, ".wb_en"}, b16.wb_en, m_en);
        if (m_valid) begin
            chk({tag, ".wb_addr"}, b16.wb_addr, m_addr);
            chk({tag, ".wb_data"}, b16.wb_data, m_data);
        end
        chk({tag, ".cpsr"}, cpsr16, m_cpsr);
        chk({tag, ".exec"}, exec16, 64'(m_exec));
        chk({tag, ".skip"}, skip16, 64'(m_skip));
        chk({tag, ".exec4"}, exec4, 64'(m_exec4));
        chk({tag, ".skip4"}, skip4, 64'(m_skip4));
        chk({tag, ".wb_valid4"}, b4.wb_valid, m_valid);
    endtask

    // One clock cycle: the task is called in the low phase. It drives the
    // inputs, checks in_ready, advances the model at the edge, then checks
    // the registered outputs.
    task automatic step(input string tag, input bit v, input bit [3:0] c, input bit s,
                        input bit [31:0] r, input bit [3:0] f, input bit wbk,
                        input bit [3:0] d, input bit fl, input bit rdy);
        bit acc, p;
        b16.in_valid = v; b16.cond = c; b16.set_flags = s; b16.alu_result = r;
        b16.alu_flags = f; b16.alu_writeback = wbk; b16.dest_reg = d;
        b16.flush = fl; b16.wb_ready = rdy;
        #1;
        chk({tag, ".in_ready"}, b16.in_ready, !m_valid || rdy);
        acc = v && (!m_valid || rdy) && !fl;
        p = cond_ok(c, m_cpsr);
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_en = 0;
        end else if (acc) begin
            m_valid = 1; m_en = p && wbk; m_addr = d; m_data = r;
        end else if (rdy) begin
            m_valid = 0; m_en = 0;
        end
        if (acc) begin
            if (p && s) m_cpsr = f;
            if (p) begin
                if (m_exec < 65535) m_exec++;
                if (m_exec4 < 15) m_exec4++;
            end else begin
                if (m_skip < 65535) m_skip++;
                if (m_skip4 < 15) m_skip4++;
            end
        end
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Reset is asserted in the middle of the low phase, away from any edge, and
    // released on the following negedge.
    task automatic do_reset(input string tag);
        b16.in_valid = 0; b16.flush = 0; b16.wb_ready = 0;
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk({tag, ".rst_in_ready"}, b16.in_ready, 1);
        check_outputs({tag, ".rst"});
        chk({tag, ".rst_addr"}, b16.wb_addr, 0);
        chk({tag, ".rst_data"}, b16.wb_data, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit [3:0] sv_cpsr;
        int sv_exec, sv_skip;
        reset = 1'b0;
        b16.in_valid = 0; b16.cond = 0; b16.set_flags = 0; b16.alu_result = 0;
        b16.alu_flags = 0; b16.alu_writeback = 0; b16.dest_reg = 0;
        b16.flush = 0; b16.wb_ready = 0;
        model_clear();
        #3;
        check_outputs("init");
        chk("init.in_ready", b16.in_ready, 1);
        @(negedge clk);
        reset = 1'b1;

        // CMP sets Z, then ADDEQ executes and writes r3
        step("r040a", 1, 4'hE, 1, 32'h0, 4'b0001, 0, 4'h0, 0, 1);
        step("r040b", 1, 4'h0, 0, 32'h0A, 4'b0000, 1, 4'h3, 0, 1);
        chk("r040.cpsr", cpsr16, 4'b0001);
        chk("r040.wb_en", b16.wb_en, 1);
        chk("r040.wb_addr", b16.wb_addr, 3);
        chk("r040.wb_data", b16.wb_data, 32'h0A);
        chk("r040.exec", exec16, 2);

        // EQ with Z clear: the op is skipped but still occupies the slot
        do_reset("r041");
        step("r041", 1, 4'h0, 1, 32'h55, 4'b1111, 1, 4'h2, 0, 1);
        chk("r041.wb_valid", b16.wb_valid, 1);
        chk("r041.wb_en", b16.wb_en, 0);
        chk("r041.wb_data", b16.wb_data, 32'h55);
        chk("r041.cpsr", cpsr16, 0);
        chk("r041.skip", skip16, 1);

        // backpressure, then a consume and accept in the same cycle
        do_reset("r042");
        step("r042a", 1, 4'hE, 0, 32'h11, 4'h0, 1, 4'h5, 0, 0);
        for (int i = 0; i < 3; i++)
            step("r042hold", 1, 4'hE, 0, 32'h99, 4'h0, 1, 4'h7, 0, 0);
        chk("r042.held_data", b16.wb_data, 32'h11);
        step("r042b", 1, 4'hE, 0, 32'h22, 4'h0, 1, 4'h6, 0, 1);
        chk("r042.replaced", b16.wb_data, 32'h22);
        chk("r042.valid", b16.wb_valid, 1);

        // flush with an op held and in_valid high
        sv_cpsr = m_cpsr; sv_exec = m_exec; sv_skip = m_skip;
        step("r043", 1, 4'hE, 1, 32'h33, 4'hF, 1, 4'h1, 1, 0);
        chk("r043.valid", b16.wb_valid, 0);
        chk("r043.cpsr", cpsr16, sv_cpsr);
        chk("r043.exec", exec16, 64'(sv_exec));
        chk("r043.skip", skip16, 64'(sv_skip));

        // saturation of the 4-bit counter instance
        do_reset("r044");
        for (int i = 0; i < 17; i++)
            step("r044", 1, 4'hE, 0, 32'(i), 4'h0, 1, 4'(i), 0, 1);
        chk("r044.exec4", exec4, 4'hF);
        chk("r044.exec16", exec16, 17);

        // asynchronous reset while an op is held
        step("r045a", 1, 4'hE, 0, 32'hDEAD, 4'h0, 1, 4'h9, 0, 0);
        do_reset("r045");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 199) == 0) do_reset("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cond_writeback_stage.md
COND_WRITEBACK_STAGE -- requirements
Module: cond_writeback_stage

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of result and writeback data.
REQ-002 Parameter CNT_WIDTH, 16, width of the executed and skipped counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream ALU op available this cycle.
REQ-006 in_ready  output  1  stage can accept an op this cycle.
REQ-007 cond  input  4  ARM condition field of the op.
REQ-008 set_flags  input  1  S-bit: op updates CPSR if executed.
REQ-009 alu_result  input  DATA_WIDTH  ALU result.
REQ-010 alu_flags  input  4  ALU flags: bit0 Z, bit1 C, bit2 N, bit3 V.
REQ-011 alu_writeback  input  1  ALU writeback request (0 for TST/TEQ/CMP/CMN).
REQ-012 dest_reg  input  4  destination register number.
REQ-013 flush  input  1  discard held op and block the current accept.
REQ-014 wb_valid  output  1  writeback slot holds an op.
REQ-015 wb_ready  input  1  register file consumes the held op.
REQ-016 wb_en  output  1  register-file write enable, qualified by wb_valid.
REQ-017 wb_addr  output  4  register-file write address.
REQ-018 wb_data  output  DATA_WIDTH  register-file write data.
REQ-019 cpsr  output  4  current flag register, same bit order as alu_flags.
REQ-020 exec_count  output  CNT_WIDTH  count of ops accepted with condition pass.
REQ-021 skip_count  output  CNT_WIDTH  count of ops accepted with condition fail.

Function
REQ-022 An op SHALL be accepted on a rising edge when in_valid=1, in_ready=1 and flush=0.
REQ-023 in_ready SHALL be combinational: !wb_valid | wb_ready.
REQ-024 Pass SHALL be evaluated against the registered cpsr at the accept edge, so an op sees the flags written by the op accepted on the previous edge.
REQ-025 Condition table: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
REQ-026 Condition table: 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never (fail).
REQ-027 On accept with pass=1 and set_flags=1, cpsr SHALL load alu_flags on that edge; otherwise cpsr SHALL hold.
REQ-028 On accept, the stage SHALL register wb_valid=1, wb_en=pass&alu_writeback, wb_addr=dest_reg, wb_data=alu_result.
REQ-029 A failed op SHALL still occupy the slot with wb_en=0 and wb_data=alu_result.
REQ-030 When wb_valid=1, wb_ready=1 and there is no accept, the next state SHALL be wb_valid=0 and wb_en=0.
REQ-031 When wb_valid=1 and wb_ready=0, wb_valid, wb_en, wb_addr and wb_data SHALL hold.
REQ-032 Simultaneous consume and accept SHALL replace the slot contents with no bubble.
REQ-033 flush=1 SHALL force wb_valid=0 and wb_en=0 next cycle, suppress the accept, leave cpsr unchanged and leave the counters unchanged.
REQ-034 On each accept, exec_count SHALL increment on pass and skip_count SHALL increment on fail; both SHALL saturate at all-ones with no wrap.
REQ-035 Latency from accept edge to wb_valid/wb_en visible SHALL be one cycle.

Reset
REQ-036 reset=0 SHALL asynchronously clear cpsr, wb_valid, wb_en, wb_addr, wb_data, exec_count and skip_count to 0.
REQ-037 in_ready SHALL read 1 during reset and after reset release.
REQ-038 A reset asserted while an op is held SHALL drop that op with no writeback.
REQ-039 The first accept SHALL occur no earlier than the first rising edge after reset deasserts.

Verification
REQ-040 CMP then conditional ADD: accept cond=E, set_flags=1, alu_flags=0001, alu_writeback=0; next cycle accept cond=0 (EQ), alu_writeback=1, dest_reg=3, alu_result=0x0A -> cpsr=0001, second op wb_en=1, wb_addr=3, wb_data=0x0A, exec_count=2.
REQ-041 Failed condition: cpsr=0000, accept cond=0 (EQ), set_flags=1, alu_flags=1111 -> wb_valid=1, wb_en=0, cpsr remains 0000, skip_count=1.
REQ-042 Backpressure: hold wb_ready=0 for 3 cycles after an accept -> in_ready=0, outputs hold; wb_ready=1 with in_valid=1 -> back-to-back replacement with no bubble.
REQ-043 Flush: flush=1 with in_valid=1 and an op held -> next cycle wb_valid=0, cpsr and counters unchanged.
REQ-044 Saturation: CNT_WIDTH=4, accept 17 AL ops -> exec_count=0xF.
REQ-045 Async reset mid-op: drive reset low between clock edges while wb_valid=1 -> all outputs 0 immediately, in_ready=1.
